// File: rtl/gaplus_video_pkg.sv
// Shared constants, pixel-flag struct and priority resolver for the Gaplus video mixer.
// The optional layer mask (GAPLUS_MIX_LAYER_MASK_EN) only feeds the layer_en field.
package gaplus_video_pkg;

    localparam int         MIX_LAT       = 5;
    localparam int         RGB_W         = 4;
    localparam logic [7:0] SP_TRANSP_DEF = 8'hFF;
    localparam logic       PAL_SEL_BG    = 1'b0;
    localparam logic       PAL_SEL_SP    = 1'b1;

    // BG and sprite flags that travel one stage behind the sprite CLUT address
    typedef struct packed {
        logic [7:0] bg_idx;
        logic       bg_pri;
        logic       sp_empty;
        logic [1:0] layer_en;
    } mix_flags_t;

    // A disabled BG layer falls through to the backdrop entry rather than its own index
    function automatic logic [8:0] resolve_pal_addr(
        input logic [7:0] sp_code,
        input mix_flags_t flags,
        input logic [7:0] transp
    );
        logic spr_vis;
        logic bg_vis;
        spr_vis = flags.layer_en[1] && !flags.sp_empty && (sp_code != transp);
        bg_vis  = flags.layer_en[0] && (flags.bg_idx[1:0] != 2'b00);
        if (spr_vis && !(flags.bg_pri && bg_vis)) begin
            return {PAL_SEL_SP, sp_code};
        end else if (flags.layer_en[0]) begin
            return {PAL_SEL_BG, flags.bg_idx};
        end else begin
            return {PAL_SEL_BG, 8'h00};
        end
    endfunction

endpackage

// File: rtl/gaplus_delay_line.sv
// N-stage shift register with synchronous reset to RST_VAL; every stage is exposed
// so callers can tap intermediate delays.
module gaplus_delay_line #(
    parameter int           W       = 1,
    parameter int           N       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [W-1:0]          i_d,
    output logic [N-1:0][W-1:0]   o_stages
);

    logic [N-1:0][W-1:0] r_stages;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stages <= {N{RST_VAL}};
        end else begin
            r_stages[0] <= i_d;
            for (int k = 1; k < N; k++) begin
                r_stages[k] <= r_stages[k-1];
            end
        end
    end

    assign o_stages = r_stages;

endmodule

// File: rtl/gaplus_video_mixer.sv
// Gaplus sprite/BG mixer: fixed 5-cycle pipeline from pixel indices to blanked RGB.
// Define GAPLUS_MIX_LAYER_MASK_EN to add the i_layer_en per-layer enable input.
module gaplus_video_mixer #(
    parameter logic [7:0] SP_TRANSP = gaplus_video_pkg::SP_TRANSP_DEF,
    parameter int         RGB_W     = gaplus_video_pkg::RGB_W
) (
    input  logic               i_vclk,
    input  logic               i_reset,
    input  logic               i_hb,
    input  logic               i_vb,
    input  logic [8:0]         i_sp_idx,
    input  logic [7:0]         i_bg_idx,
    input  logic               i_bg_pri,
`ifdef GAPLUS_MIX_LAYER_MASK_EN
    input  logic [1:0]         i_layer_en,
`endif
    output logic [8:0]         o_spclut_a,
    input  logic [7:0]         i_spclut_d,
    output logic [8:0]         o_pal_a,
    input  logic [3*RGB_W-1:0] i_pal_d,
    output logic [RGB_W-1:0]   o_r,
    output logic [RGB_W-1:0]   o_g,
    output logic [RGB_W-1:0]   o_b,
    output logic               o_hb,
    output logic               o_vb
);

    import gaplus_video_pkg::*;

    logic [1:0]                  w_layer_en;
    logic [8:0]                  r_spclut_a;
    logic [7:0]                  r_bg_idx1;
    logic                        r_bg_pri1;
    logic [1:0]                  r_layer_en1;
    mix_flags_t                  w_s1_flags;
    logic [0:0][$bits(mix_flags_t)-1:0] w_s2_stages;
    mix_flags_t                  w_s2_flags;
    logic [8:0]                  r_pal_a;
    logic [MIX_LAT-1:0][1:0]     w_blank_stages;
    logic                        w_blank5;
    logic                        w_unused_blank;
    logic [3*RGB_W-1:0]          r_rgb;

`ifdef GAPLUS_MIX_LAYER_MASK_EN
    assign w_layer_en = i_layer_en;
`else
    assign w_layer_en = 2'b11;
`endif

    // S1: the registered sprite index doubles as the sprite CLUT PROM address
    always_ff @(posedge i_vclk) begin
        if (i_reset) begin
            r_spclut_a  <= '0;
            r_bg_idx1   <= '0;
            r_bg_pri1   <= 1'b0;
            r_layer_en1 <= '0;
        end else begin
            r_spclut_a  <= i_sp_idx;
            r_bg_idx1   <= i_bg_idx;
            r_bg_pri1   <= i_bg_pri;
            r_layer_en1 <= w_layer_en;
        end
    end

    assign w_s1_flags.bg_idx   = r_bg_idx1;
    assign w_s1_flags.bg_pri   = r_bg_pri1;
    assign w_s1_flags.sp_empty = (r_spclut_a[2:0] == 3'd0);
    assign w_s1_flags.layer_en = r_layer_en1;

    // S2 lines the BG side up with the CLUT PROM's one-cycle read latency
    gaplus_delay_line #(
        .W       ($bits(mix_flags_t)),
        .N       (1),
        .RST_VAL ('0)
    ) u_flag_align (
        .i_clk    (i_vclk),
        .i_reset  (i_reset),
        .i_d      (w_s1_flags),
        .o_stages (w_s2_stages)
    );

    assign w_s2_flags = mix_flags_t'(w_s2_stages[0]);

    always_ff @(posedge i_vclk) begin
        if (i_reset) begin
            r_pal_a <= '0;
        end else begin
            r_pal_a <= resolve_pal_addr(i_spclut_d, w_s2_flags, SP_TRANSP);
        end
    end

    // Blank flags reset high so the screen stays dark until real pixels reach S5
    gaplus_delay_line #(
        .W       (2),
        .N       (MIX_LAT),
        .RST_VAL (2'b11)
    ) u_blank_delay (
        .i_clk    (i_vclk),
        .i_reset  (i_reset),
        .i_d      ({i_hb, i_vb}),
        .o_stages (w_blank_stages)
    );

    assign w_blank5       = |w_blank_stages[MIX_LAT-2];
    assign w_unused_blank = |w_blank_stages[MIX_LAT-3:0];

    always_ff @(posedge i_vclk) begin
        if (i_reset) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_blank5 ? '0 : i_pal_d;
        end
    end

    assign o_spclut_a = r_spclut_a;
    assign o_pal_a    = r_pal_a;
    assign o_r        = r_rgb[3*RGB_W-1 -: RGB_W];
    assign o_g        = r_rgb[2*RGB_W-1 -: RGB_W];
    assign o_b        = r_rgb[RGB_W-1 -: RGB_W];
    assign o_hb       = w_blank_stages[MIX_LAT-1][1];
    assign o_vb       = w_blank_stages[MIX_LAT-1][0];

endmodule

// File: tb/tb_gaplus_video_mixer.sv
// Directed bench for gaplus_video_mixer with behavioural sync PROM models.
// Layer-mask steps run only when GAPLUS_MIX_LAYER_MASK_EN is defined.
module tb_gaplus_video_mixer;

    logic        clk = 1'b0;
    logic        reset;
    logic        hb;
    logic        vb;
    logic [8:0]  spIdx;
    logic [7:0]  bgIdx;
    logic        bgPri;
    logic [1:0]  layerEn;
    logic [8:0]  spclutA;
    logic [7:0]  spclutD;
    logic [8:0]  palA;
    logic [11:0] palD;
    logic [3:0]  rOut;
    logic [3:0]  gOut;
    logic [3:0]  bOut;
    logic        hbOut;
    logic        vbOut;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    gaplus_video_mixer dut (
        .i_vclk     (clk),
        .i_reset    (reset),
        .i_hb       (hb),
        .i_vb       (vb),
        .i_sp_idx   (spIdx),
        .i_bg_idx   (bgIdx),
        .i_bg_pri   (bgPri),
`ifdef GAPLUS_MIX_LAYER_MASK_EN
        .i_layer_en (layerEn),
`endif
        .o_spclut_a (spclutA),
        .i_spclut_d (spclutD),
        .o_pal_a    (palA),
        .i_pal_d    (palD),
        .o_r        (rOut),
        .o_g        (gOut),
        .o_b        (bOut),
        .o_hb       (hbOut),
        .o_vb       (vbOut)
    );

    function automatic logic [7:0] spclutModel(input logic [8:0] a);
        case (a)
            9'h01B:  return 8'h3C;
            9'h01C:  return 8'hFF;
            9'h018:  return 8'h3C;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [11:0] palModel(input logic [8:0] a);
        return (a == 9'h005) ? 12'hABC : {3'b000, a};
    endfunction

    // Synchronous PROMs: address sampled on the edge, data valid one cycle later
    always @(posedge clk) begin
        spclutD <= spclutModel(spclutA);
        palD    <= palModel(palA);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [8:0] sp, input logic [7:0] bg,
                                 input logic pri, input logic h, input logic v);
        spIdx = sp;
        bgIdx = bg;
        bgPri = pri;
        hb    = h;
        vb    = v;
    endtask

    task automatic checkOutput(input string tag, input logic [11:0] observed,
                               input logic [11:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkPalAfter3(input string tag, input logic [8:0] sp, input logic [7:0] bg,
                                  input logic pri, input logic [8:0] expected);
        applyStimulus(sp, bg, pri, 1'b0, 1'b0);
        step();
        checkOutput({tag, "_spclut_a"}, {3'b000, spclutA}, {3'b000, sp});
        step();
        step();
        checkOutput({tag, "_pal_a"}, {3'b000, palA}, {3'b000, expected});
    endtask

    logic hbHist [20];
    int   blankCount;

    initial begin
        reset   = 1'b1;
        layerEn = 2'b11;
        applyStimulus(9'h01B, 8'h05, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("reset_rgb", {rOut, gOut, bOut}, 12'h000);
            checkOutput("reset_blank", {10'd0, hbOut, vbOut}, 12'h003);
        end
        checkOutput("reset_spclut_a", {3'b000, spclutA}, 12'h000);
        checkOutput("reset_pal_a", {3'b000, palA}, 12'h000);

        reset = 1'b0;
        applyStimulus(9'h000, 8'h06, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
            checkOutput("post_reset_rgb", {rOut, gOut, bOut}, 12'h000);
            checkOutput("post_reset_blank", {10'd0, hbOut, vbOut}, 12'h003);
        end
        step();
        checkOutput("first_pixel_rgb", {rOut, gOut, bOut}, 12'h006);
        checkOutput("first_pixel_blank", {10'd0, hbOut, vbOut}, 12'h000);

        applyStimulus(9'h000, 8'h05, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
            checkOutput("latency_old_rgb", {rOut, gOut, bOut}, 12'h006);
        end
        step();
        checkOutput("latency_new_rgb", {rOut, gOut, bOut}, 12'hABC);

        checkPalAfter3("prio_bgpri0", 9'h01B, 8'h06, 1'b0, 9'h13C);
        step();
        step();
        checkOutput("prio_sprite_rgb", {rOut, gOut, bOut}, 12'h13C);
        checkPalAfter3("prio_bgpri1", 9'h01B, 8'h06, 1'b1, 9'h006);
        checkPalAfter3("prio_bg_transp", 9'h01B, 8'h04, 1'b1, 9'h13C);
        checkPalAfter3("transp_clut_ff", 9'h01C, 8'h06, 1'b0, 9'h006);
        checkPalAfter3("transp_sp_empty", 9'h018, 8'h07, 1'b0, 9'h007);
        checkPalAfter3("transp_backdrop", 9'h01C, 8'h00, 1'b0, 9'h000);
        checkPalAfter3("transp_bg_idx", 9'h000, 8'h04, 1'b0, 9'h004);

`ifdef GAPLUS_MIX_LAYER_MASK_EN
        layerEn = 2'b01;
        checkPalAfter3("mask_bg_only", 9'h01B, 8'h06, 1'b0, 9'h006);
        layerEn = 2'b10;
        checkPalAfter3("mask_sp_only", 9'h01B, 8'h06, 1'b0, 9'h13C);
        layerEn = 2'b00;
        checkPalAfter3("mask_none", 9'h01B, 8'h06, 1'b0, 9'h000);
        layerEn = 2'b11;
`endif

        applyStimulus(9'h000, 8'h05, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
        end
        blankCount = 0;
        for (int i = 0; i < 20; i++) begin
            logic expHb;
            hb = (i >= 3) && (i < 11);
            hbHist[i] = hb;
            step();
            expHb = (i >= 4) ? hbHist[i-4] : 1'b0;
            if (hbOut) blankCount++;
            checkOutput("hblank_flag", {11'd0, hbOut}, {11'd0, expHb});
            checkOutput("hblank_rgb", {rOut, gOut, bOut}, expHb ? 12'h000 : 12'hABC);
        end
        checkOutput("hblank_width", blankCount[11:0], 12'd8);

        vb = 1'b1;
        step();
        vb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        step();
        checkOutput("vblank_flag", {11'd0, vbOut}, 12'h001);
        checkOutput("vblank_rgb", {rOut, gOut, bOut}, 12'h000);
        step();
        checkOutput("vblank_end_flag", {11'd0, vbOut}, 12'h000);
        checkOutput("vblank_end_rgb", {rOut, gOut, bOut}, 12'hABC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
